// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core front end: widths, reset PC, bubble
// word and the IF/ID register control encoding.
package core_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int PC_W       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

  // IF/ID register action for the coming edge.
  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_ctrl_e;

  // Drop the byte-offset bits so a target is always word aligned.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~(PC_W'(INST_BYTES) - 1'b1);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures (pc, inst) with a valid flag.
// Flush and reset both leave a bubble: pc=0, inst=NOP, valid=0.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP = NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  ifid_ctrl_e      ctrl,
  input  logic [PC_W-1:0] d_pc,
  input  logic [ILEN-1:0] d_inst,
  output logic [PC_W-1:0] pc,
  output logic [ILEN-1:0] inst,
  output logic            valid
);

  // Register update: reset/flush insert a bubble, load captures, hold keeps.
  always_ff @(posedge clk) begin
    if (reset || ctrl == IFID_FLUSH) begin
      pc    <= '0;
      inst  <= NOP;
      valid <= 1'b0;
    end else if (ctrl == IFID_LOAD) begin
      pc    <= d_pc;
      inst  <= d_inst;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory and
// captures the returned word into IF/ID. Redirect beats stall; reset beats all.
// Optional fetch counter enabled by defining IF_PERF_CNT_EN.
module if_stage
  import core_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter logic [ILEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_inst,
  output logic [PC_W-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_inst,
  output logic            if_id_valid,
  output logic [31:0]     fetch_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  ifid_ctrl_e      ifid_ctrl;

  // Next-PC mux and IF/ID control: redirect > stall > sequential advance.
  always_comb begin
    pc_next   = pc + PC_W'(INST_BYTES);
    ifid_ctrl = IFID_LOAD;
    if (redirect_valid) begin
      pc_next   = word_align(redirect_pc);
      ifid_ctrl = IFID_FLUSH;
    end else if (stall) begin
      pc_next   = pc;
      ifid_ctrl = IFID_HOLD;
    end
  end

  // PC register; memory address comes straight from it.
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  assign imem_addr = pc;

  if_id_reg #(.NOP(NOP_INST)) u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .ctrl   (ifid_ctrl),
    .d_pc   (pc),
    .d_inst (imem_inst),
    .pc     (if_id_pc),
    .inst   (if_id_inst),
    .valid  (if_id_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Count every edge that loads a real instruction into IF/ID.
  always_ff @(posedge clk) begin
    if (reset)                       fetch_cnt_q <= '0;
    else if (ifid_ctrl == IFID_LOAD) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_count = fetch_cnt_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural instruction memory, a PC model and an
// expected-capture queue filled as each fetch is launched.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] if_id_pc, if_id_inst, fetch_count;
  logic        if_id_valid;

  // Second instance with default parameters, used to check RESET_PC=0.
  logic [31:0] d0_addr, d0_inst, d0_pc, d0_iinst, d0_fc;
  logic        d0_valid;

  int n_checks;
  int n_fails;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  int          exp_count;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h04:       return 32'h0010_0293;
      32'h08:       return 32'h0030_0313;
      32'h0C:       return 32'h0062_B223;
      32'h10:       return 32'h0062_E3B3;
      32'h14:       return 32'h0053_B123;
      32'h18:       return 32'h0041_A023;
      32'h1C:       return 32'h0062_82B3;
      32'h20:       return 32'h00A0_0593;
      32'h24:       return 32'h0000_006F;
      32'hFFFF_FFFC: return 32'h0FF0_0093;
      default:      return {16'hBAD0, a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] fc_exp();
`ifdef IF_PERF_CNT_EN
    return exp_count;
`else
    return 32'h0;
`endif
  endfunction

  assign imem_inst = mem_rd(imem_addr);
  assign d0_inst   = mem_rd(d0_addr);

  if_stage #(.RESET_PC(32'h4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  if_stage dut0 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(d0_addr), .imem_inst(d0_inst),
    .if_id_pc(d0_pc), .if_id_inst(d0_iinst), .if_id_valid(d0_valid),
    .fetch_count(d0_fc)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    n_checks++; if (imem_addr !== 32'h4) begin n_fails++; $display("FAIL reset_pc4: got %h required %h", imem_addr, 32'h4); end
    n_checks++; if (d0_addr !== 32'h0) begin n_fails++; $display("FAIL reset_pc0: got %h required %h", d0_addr, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b required 0", if_id_valid); end
    n_checks++; if (if_id_inst !== NOP) begin n_fails++; $display("FAIL reset_inst: got %h required %h", if_id_inst, NOP); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fails++; $display("FAIL reset_ifid_pc: got %h required 0", if_id_pc); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fails++; $display("FAIL reset_count: got %h required 0", fetch_count); end
    n_checks++; if (d0_valid !== 1'b0 || d0_iinst !== NOP || d0_pc !== 32'h0 || d0_fc !== 32'h0) begin
      n_fails++; $display("FAIL reset_dut0: got v=%b inst=%h pc=%h fc=%h required v=0 inst=%h pc=0 fc=0", d0_valid, d0_iinst, d0_pc, d0_fc, NOP);
    end
    model_pc = 32'h4; exp_count = 0;
  endtask

  task automatic test_fetch();
    logic [63:0] e;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({model_pc, mem_rd(model_pc)});
      model_pc += 4; exp_count++;
      tick();
      e = exp_q.pop_front();
      n_checks++; if (if_id_pc !== e[63:32] || if_id_inst !== e[31:0] || if_id_valid !== 1'b1) begin
        n_fails++; $display("FAIL fetch_%0d: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1", i, if_id_pc, if_id_inst, if_id_valid, e[63:32], e[31:0]);
      end
      n_checks++; if (imem_addr !== model_pc) begin n_fails++; $display("FAIL fetch_addr_%0d: got %h required %h", i, imem_addr, model_pc); end
    end
    n_checks++; if (fetch_count !== fc_exp()) begin n_fails++; $display("FAIL fetch_count: got %0d required %0d", fetch_count, fc_exp()); end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (imem_addr !== 32'h14 || if_id_pc !== 32'h10 || if_id_inst !== 32'h0062_E3B3 || if_id_valid !== 1'b1) begin
        n_fails++; $display("FAIL stall_hold_%0d: got addr=%h pc=%h inst=%h v=%b required addr=14 pc=10 inst=0062e3b3 v=1", i, imem_addr, if_id_pc, if_id_inst, if_id_valid);
      end
      n_checks++; if (fetch_count !== fc_exp()) begin n_fails++; $display("FAIL stall_count_%0d: got %0d required %0d", i, fetch_count, fc_exp()); end
    end
    stall = 0;
    exp_q.push_back({model_pc, mem_rd(model_pc)});
    model_pc += 4; exp_count++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (if_id_inst !== e[31:0] || if_id_pc !== e[63:32] || if_id_valid !== 1'b1) begin
      n_fails++; $display("FAIL stall_release: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    stall = 1; redirect_valid = 1; redirect_pc = 32'h1F;
    model_pc = 32'h1C;
    tick();
    n_checks++; if (imem_addr !== 32'h1C || if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0) begin
      n_fails++; $display("FAIL redirect_bubble: got addr=%h v=%b inst=%h pc=%h required addr=1c v=0 inst=%h pc=0", imem_addr, if_id_valid, if_id_inst, if_id_pc, NOP);
    end
    stall = 0; redirect_valid = 0;
    exp_q.push_back({model_pc, mem_rd(model_pc)});
    model_pc += 4; exp_count++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (if_id_inst !== e[31:0] || if_id_pc !== e[63:32] || if_id_valid !== 1'b1) begin
      n_fails++; $display("FAIL redirect_target: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [31:0] tgt [2];
    tgt[0] = 32'h8; tgt[1] = 32'h11;
    for (int i = 0; i < 2; i++) begin
      redirect_valid = 1; redirect_pc = tgt[i];
      model_pc = tgt[i] & 32'hFFFF_FFFC;
      tick();
      n_checks++; if (imem_addr !== model_pc || if_id_valid !== 1'b0 || if_id_inst !== NOP) begin
        n_fails++; $display("FAIL b2b_redirect_%0d: got addr=%h v=%b inst=%h required addr=%h v=0 inst=%h", i, imem_addr, if_id_valid, if_id_inst, model_pc, NOP);
      end
    end
    redirect_valid = 0;
    exp_q.push_back({model_pc, mem_rd(model_pc)});
    model_pc += 4; exp_count++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (if_id_inst !== e[31:0] || if_id_pc !== e[63:32] || if_id_valid !== 1'b1) begin
      n_fails++; $display("FAIL b2b_resume: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    model_pc = 32'hFFFF_FFFC;
    tick();
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_target: got %h required fffffffc", imem_addr); end
    redirect_valid = 0;
    exp_q.push_back({model_pc, mem_rd(model_pc)});
    model_pc += 4; exp_count++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (imem_addr !== 32'h0 || model_pc !== 32'h0) begin n_fails++; $display("FAIL wrap_addr: got %h required 00000000", imem_addr); end
    n_checks++; if (if_id_pc !== e[63:32] || if_id_inst !== e[31:0] || if_id_valid !== 1'b1) begin
      n_fails++; $display("FAIL wrap_capture: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, e[63:32], e[31:0]);
    end
    n_checks++; if (fetch_count !== fc_exp()) begin n_fails++; $display("FAIL wrap_count: got %0d required %0d", fetch_count, fc_exp()); end
  endtask

  task automatic test_reset_priority();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h40; reset = 1;
    tick();
    exp_count = 0;
    n_checks++; if (imem_addr !== 32'h4 || if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0) begin
      n_fails++; $display("FAIL reset_priority: got addr=%h v=%b inst=%h pc=%h required addr=4 v=0 inst=%h pc=0", imem_addr, if_id_valid, if_id_inst, if_id_pc, NOP);
    end
    n_checks++; if (fetch_count !== 32'h0) begin n_fails++; $display("FAIL reset_priority_count: got %0d required 0", fetch_count); end
    n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
    reset = 0; stall = 0; redirect_valid = 0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
